neopixel_pattern_gen: RTL and testbench

Frame-based pattern generator driving the neopixel core's control write interface (write_readf/address/write_data). Every C_RATE cycles it writes one full frame, C_PIXELS consecutive words from address 0 upward, with a ready handshake. Four selectable pattern modes. A per-frame base colour and chase position advance after each frame. Sits between the PS-controlled enable/mode bits and the neopixel serialiser core.

---
 rtl/neopixel_pkg.sv | 18 +
 rtl/neopixel_frame_timer.sv | 34 +++
 rtl/neopixel_pattern_gen.sv | 154 +++++++++++++++
 tb/tb_neopixel_pattern_gen.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/neopixel_pkg.sv
// Shared constants for the neopixel pattern generator.
//   COLOR_W      - width of one GRB colour word
//   MODE_*       - pattern mode encodings seen on the mode input
//   ST_*         - frame FSM state encodings
package neopixel_pkg;

    localparam int COLOR_W = 24;

    localparam logic [1:0] MODE_SOLID = 2'd0;
    localparam logic [1:0] MODE_INCR  = 2'd1;
    localparam logic [1:0] MODE_CHASE = 2'd2;
    localparam logic [1:0] MODE_OFF   = 2'd3;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WRITE = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

endpackage

// File: rtl/neopixel_frame_timer.sv
// Frame-rate timer. Counts clock cycles while enabled and raises trig for
// one cycle every C_RATE cycles. Disabling holds the count at 0, so the first
// trig after enable rises comes C_RATE cycles later.
//   clock   - system clock
//   reset   - synchronous, active-high
//   enable  - 1 = count, 0 = hold at 0
//   trig    - one-cycle frame trigger
module neopixel_frame_timer #(
    parameter int C_RATE = 125000000
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    output logic trig
);

    localparam int CW = (C_RATE > 2) ? $clog2(C_RATE) : 1;
    localparam logic [CW-1:0] LAST = CW'(C_RATE - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clock) begin
        if (reset || !enable) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign trig = enable && (count == LAST);

endmodule

// File: rtl/neopixel_pattern_gen.sv
// Frame-based pattern generator for the neopixel core's control write port.
// Every C_RATE cycles one frame of C_PIXELS words is written to addresses
// 0..C_PIXELS-1 with a valid/ready handshake. The base colour and chase
// position advance by one step after every frame.
//   clock, reset          - system clock, synchronous active-high reset
//   enable                - lets the frame timer run
//   mode                  - SOLID / INCR / CHASE / OFF, sampled at frame start
//   clock_ctrl/reset_ctrl - clock and reset forwarded to the core
//   write_readf           - write request (valid)
//   write_ready           - core accepts when write_readf && write_ready
//   address, write_data   - pixel index and {8'h00, GRB colour}
//   busy                  - frame in progress
//   frame_done            - one-cycle pulse after the last accept
//   overrun               - one-cycle pulse for a trigger dropped while busy
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for a frame trigger
// WRITE | presenting pixel 'address', held until accepted
// DONE  | frame finished; base colour and chase position advance
module neopixel_pattern_gen
    import neopixel_pkg::*;
#(
    parameter int                 C_RATE   = 125000000,
    parameter int                 C_PIXELS = 12,
    parameter logic [COLOR_W-1:0] C_STEP   = 24'h040201
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic [1:0]  mode,
    output logic        clock_ctrl,
    output logic        reset_ctrl,
    output logic        write_readf,
    input  logic        write_ready,
    output logic [31:0] address,
    output logic [31:0] write_data,
    output logic        busy,
    output logic        frame_done,
    output logic        overrun
);

    localparam logic [15:0] LAST_PIX = 16'(C_PIXELS - 1);

    logic                trig;
    logic [1:0]          state;
    logic [1:0]          mode_q;
    logic [COLOR_W-1:0]  base;
    logic [COLOR_W-1:0]  acc;
    logic [15:0]         pos;
    logic [15:0]         pix;

    logic [COLOR_W-1:0]  frame_base;
    logic [15:0]         frame_pos;
    logic [15:0]         nxt_pix;
    logic [COLOR_W-1:0]  nxt_acc;
    logic                start;
    logic                accept;

    neopixel_frame_timer #(
        .C_RATE (C_RATE)
    ) u_timer (
        .clock  (clock),
        .reset  (reset),
        .enable (enable),
        .trig   (trig)
    );

    function automatic logic [COLOR_W-1:0] pixel_colour(
        input logic [1:0]         m,
        input logic [COLOR_W-1:0] b,
        input logic [COLOR_W-1:0] a,
        input logic               hit
    );
        logic [COLOR_W-1:0] c;
        case (m)
            MODE_SOLID: c = b;
            MODE_INCR:  c = a;
            MODE_CHASE: c = hit ? b : '0;
            default:    c = '0;
        endcase
        return c;
    endfunction

    assign clock_ctrl = clock;
    assign reset_ctrl = reset;
    assign address    = {16'h0000, pix};

    // A trigger landing in DONE starts the next frame straight away, so the
    // advanced base/position must be usable in the same cycle they are stored.
    assign frame_base = (state == ST_DONE) ? base + C_STEP : base;
    assign frame_pos  = (state == ST_DONE) ? ((pos == LAST_PIX) ? 16'd0 : pos + 16'd1) : pos;

    assign start   = trig && (state != ST_WRITE);
    assign accept  = write_readf && write_ready;
    assign nxt_pix = pix + 16'd1;
    assign nxt_acc = acc + C_STEP;
    assign overrun = trig && busy;

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= ST_IDLE;
            mode_q      <= MODE_SOLID;
            base        <= '0;
            acc         <= '0;
            pos         <= '0;
            pix         <= '0;
            write_readf <= 1'b0;
            write_data  <= '0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (state == ST_DONE) begin
                        base <= frame_base;
                        pos  <= frame_pos;
                    end
                    if (start) begin
                        mode_q      <= mode;
                        pix         <= '0;
                        acc         <= frame_base;
                        write_data  <= {8'h00, pixel_colour(mode, frame_base, frame_base,
                                                            frame_pos == 16'd0)};
                        write_readf <= 1'b1;
                        busy        <= 1'b1;
                        state       <= ST_WRITE;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_WRITE: begin
                    if (accept) begin
                        if (pix == LAST_PIX) begin
                            write_readf <= 1'b0;
                            busy        <= 1'b0;
                            frame_done  <= 1'b1;
                            pix         <= '0;
                            state       <= ST_DONE;
                        end else begin
                            pix        <= nxt_pix;
                            acc        <= nxt_acc;
                            write_data <= {8'h00, pixel_colour(mode_q, base, nxt_acc,
                                                               pos == nxt_pix)};
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_neopixel_pattern_gen.sv
// Directed bench for neopixel_pattern_gen with C_RATE=10, C_PIXELS=4.
module tb_neopixel_pattern_gen;
    import neopixel_pkg::*;

    localparam int RATE = 10;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b1;
    logic [1:0]  mode = MODE_SOLID;
    logic        write_ready = 1'b1;
    logic        clock_ctrl, reset_ctrl, write_readf, busy, frame_done, overrun;
    logic [31:0] address, write_data;

    int vecs = 0;
    int errs = 0;
    int ov_cnt = 0;

    neopixel_pattern_gen #(
        .C_RATE   (RATE),
        .C_PIXELS (4),
        .C_STEP   (24'h040201)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .mode        (mode),
        .clock_ctrl  (clock_ctrl),
        .reset_ctrl  (reset_ctrl),
        .write_readf (write_readf),
        .write_ready (write_ready),
        .address     (address),
        .write_data  (write_data),
        .busy        (busy),
        .frame_done  (frame_done),
        .overrun     (overrun)
    );

    always #5 clock = ~clock;

    always @(negedge clock) if (overrun === 1'b1) ov_cnt++;

    typedef struct {
        bit               rst;
        logic [1:0]       mode;
        logic [0:3][23:0] d;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset(input logic [1:0] m);
        @(negedge clock);
        reset = 1'b1;
        mode  = m;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    // Negedges from reset release until write_readf is seen.
    task automatic measure_lat(output int lat);
        lat = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            lat++;
            if (write_readf === 1'b1) break;
        end
    endtask

    task automatic check_pixels(input int first, input bit first_seen, input logic [0:3][23:0] d);
        for (int p = first; p < 4; p++) begin
            bit seen;
            seen = (p == first) && first_seen;
            for (int w = 0; w < 40 && !seen; w++) begin
                @(negedge clock);
                if (write_readf === 1'b1) seen = 1'b1;
            end
            if (!seen) begin
                chk("write_timeout", 32'd0, 32'd1);
                return;
            end
            chk($sformatf("addr%0d", p), address, 32'(p));
            chk($sformatf("data%0d", p), write_data, {8'h00, d[p]});
        end
        @(negedge clock);
        chk("frame_done", {31'b0, frame_done}, 32'd1);
        chk("busy_after", {31'b0, busy}, 32'd0);
    endtask

    initial begin
        int lat;
        int ov0;
        bit bad;
        bit found;

        tbl[0]  = '{1'b1, MODE_SOLID, {24'h000000, 24'h000000, 24'h000000, 24'h000000}};
        tbl[1]  = '{1'b0, MODE_SOLID, {24'h040201, 24'h040201, 24'h040201, 24'h040201}};
        tbl[2]  = '{1'b1, MODE_INCR,  {24'h000000, 24'h040201, 24'h080402, 24'h0C0603}};
        tbl[3]  = '{1'b1, MODE_CHASE, {24'h000000, 24'h000000, 24'h000000, 24'h000000}};
        tbl[4]  = '{1'b0, MODE_CHASE, {24'h000000, 24'h040201, 24'h000000, 24'h000000}};
        tbl[5]  = '{1'b0, MODE_CHASE, {24'h000000, 24'h000000, 24'h080402, 24'h000000}};
        tbl[6]  = '{1'b0, MODE_CHASE, {24'h000000, 24'h000000, 24'h000000, 24'h0C0603}};
        tbl[7]  = '{1'b0, MODE_CHASE, {24'h100804, 24'h000000, 24'h000000, 24'h000000}};
        tbl[8]  = '{1'b0, MODE_OFF,   {24'h000000, 24'h000000, 24'h000000, 24'h000000}};
        tbl[9]  = '{1'b0, MODE_INCR,  {24'h180C06, 24'h1C0E07, 24'h201008, 24'h241209}};
        tbl[10] = '{1'b0, MODE_SOLID, {24'h1C0E07, 24'h1C0E07, 24'h1C0E07, 24'h1C0E07}};

        // Reset state
        repeat (3) @(negedge clock);
        chk("rst_outputs", {28'b0, write_readf, busy, frame_done, overrun}, 32'd0);
        chk("rst_address", address, 32'd0);
        chk("rst_data", write_data, 32'd0);
        chk("reset_ctrl_hi", {31'b0, reset_ctrl}, 32'd1);

        // Table of frames; base and chase position carry across non-reset rows
        for (int i = 0; i < 11; i++) begin
            if (tbl[i].rst) begin
                do_reset(tbl[i].mode);
                measure_lat(lat);
                chk("latency", 32'(lat), 32'd10);
                check_pixels(0, write_readf === 1'b1, tbl[i].d);
            end else begin
                mode = tbl[i].mode;
                check_pixels(0, 1'b0, tbl[i].d);
            end
        end
        chk("reset_ctrl_lo", {31'b0, reset_ctrl}, 32'd0);

        // Stall on address 1 for 3 cycles
        do_reset(MODE_INCR);
        measure_lat(lat);
        chk("stall_a0", address, 32'd0);
        @(negedge clock);
        chk("stall_a1", address, 32'd1);
        write_ready = 1'b0;
        bad = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            if (write_readf !== 1'b1 || address !== 32'd1 || write_data !== 32'h00040201) bad = 1'b1;
        end
        chk("stall_hold", {31'b0, bad}, 32'd0);
        write_ready = 1'b1;
        check_pixels(2, 1'b0, {24'h000000, 24'h040201, 24'h080402, 24'h0C0603});

        // Long stall across a trigger: one overrun, frame not restarted
        do_reset(MODE_SOLID);
        measure_lat(lat);
        write_ready = 1'b0;
        ov0 = ov_cnt;
        bad = 1'b0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clock);
            if (write_readf !== 1'b1 || address !== 32'd0 || busy !== 1'b1) bad = 1'b1;
        end
        chk("overrun_hold", {31'b0, bad}, 32'd0);
        write_ready = 1'b1;
        check_pixels(1, 1'b0, {24'h000000, 24'h000000, 24'h000000, 24'h000000});
        chk("overrun_count", 32'(ov_cnt - ov0), 32'd1);

        // Reset while pixel 2 of the second frame is pending
        do_reset(MODE_SOLID);
        measure_lat(lat);
        check_pixels(0, write_readf === 1'b1, {24'h0, 24'h0, 24'h0, 24'h0});
        found = 1'b0;
        for (int w = 0; w < 40 && !found; w++) begin
            @(negedge clock);
            if (write_readf === 1'b1 && address === 32'd2) found = 1'b1;
        end
        chk("mid_found", {31'b0, found}, 32'd1);
        chk("mid_data", write_data, 32'h00040201);
        reset = 1'b1;
        @(negedge clock);
        chk("mid_rst_ctl", {28'b0, write_readf, busy, frame_done, overrun}, 32'd0);
        chk("mid_rst_addr", address, 32'd0);
        chk("mid_rst_data", write_data, 32'd0);
        reset = 1'b0;
        measure_lat(lat);
        chk("mid_latency", 32'(lat), 32'd10);
        check_pixels(0, write_readf === 1'b1, {24'h0, 24'h0, 24'h0, 24'h0});

        // Enable dropped mid-frame: frame completes, nothing follows
        found = 1'b0;
        for (int w = 0; w < 40 && !found; w++) begin
            @(negedge clock);
            if (write_readf === 1'b1) found = 1'b1;
        end
        enable = 1'b0;
        check_pixels(0, found, {24'h040201, 24'h040201, 24'h040201, 24'h040201});
        bad = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clock);
            if (write_readf !== 1'b0) bad = 1'b1;
        end
        chk("no_frame_disabled", {31'b0, bad}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
